// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - command-driven J/K strobe controller with settle, readback check and retry
// Converts LOAD/SET/CLEAR/TOGGLE commands into excitation-table J/K pulses for an external JK bank.
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_WAIT  = 2'b10,
        S_CHECK = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [CW-1:0]    settle_q, settle_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;

    logic [WIDTH-1:0] op_tgt;
    logic [WIDTH-1:0] diff;

    always_comb begin
        op_tgt = in_data;
        case (in_op)
            OP_LOAD:   op_tgt = in_data;
            OP_SET:    op_tgt = '1;
            OP_CLEAR:  op_tgt = '0;
            OP_TOGGLE: op_tgt = ~q_fb;
            default:   op_tgt = in_data;
        endcase
    end

    assign diff = (q_fb ^ tgt_q) & mask_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        snap_d     = snap_q;
        tgt_d      = tgt_q;
        settle_d   = settle_q;
        retry_d    = retry_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_bits_d = err_bits_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mask_d     = in_mask;
                    snap_d     = q_fb;
                    tgt_d      = (in_mask & op_tgt) | (~in_mask & q_fb);
                    retry_d    = '0;
                    err_bits_d = '0;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (settle_q == CW'(SETTLE - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + CW'(1);
                end
            end
            S_CHECK: begin
                if (diff == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    // Re-drive from the bank's present Q so a TOGGLE is never applied twice
                    retry_d = retry_q + RW'(1);
                    snap_d  = q_fb;
                    state_d = S_DRIVE;
                end else begin
                    err_d      = 1'b1;
                    err_bits_d = diff;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            snap_q     <= '0;
            tgt_q      <= '0;
            settle_q   <= '0;
            retry_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            snap_q     <= snap_d;
            tgt_q      <= tgt_d;
            settle_q   <= settle_d;
            retry_q    <= retry_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
        end
    end

    // Excitation-table strobes; J=K=1 is impossible since each bit is either ~S&T or S&~T
    assign j        = (state_q == S_DRIVE) ? (mask_q & ~snap_q & tgt_q) : '0;
    assign k        = (state_q == S_DRIVE) ? (mask_q & snap_q & ~tgt_q) : '0;
    assign in_ready = (state_q == S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_bits = err_bits_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - self-checking bench for jk_bank_driver with a behavioural JK bank
module tb_jk_bank_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_mask;
    logic [3:0] in_data;
    logic [3:0] q_fb;
    logic [3:0] j;
    logic [3:0] k;
    logic       done;
    logic       err;
    logic [3:0] err_bits;

    int n_cmp = 0;
    int n_bad = 0;

    // 0: healthy, 1: bit0 stuck at 0, 2: bit2 ignores its first strobe
    int         fault_mode = 0;
    logic       seen2 = 1'b0;
    logic [3:0] bank_q = 4'b0000;

    always #5 clk = ~clk;

    jk_bank_driver #(.WIDTH(4), .SETTLE(2), .MAX_RETRY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_mask  (in_mask),
        .in_data  (in_data),
        .q_fb     (q_fb),
        .j        (j),
        .k        (k),
        .done     (done),
        .err      (err),
        .err_bits (err_bits)
    );

    function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj,
                                           input logic [3:0] kk, input int fm, input logic s2);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            case ({jj[i], kk[i]})
                2'b10:   n[i] = 1'b1;
                2'b01:   n[i] = 1'b0;
                2'b11:   n[i] = ~q[i];
                default: n[i] = q[i];
            endcase
        end
        if (fm == 2 && !s2) n[2] = q[2];
        if (fm == 1) n[0] = 1'b0;
        return n;
    endfunction

    always @(posedge clk) begin
        if (fault_mode != 2) seen2 <= 1'b0;
        else if (j[2] | k[2]) seen2 <= 1'b1;
        bank_q <= jk_next(bank_q, j, k, fault_mode, seen2);
    end

    assign q_fb = bank_q;

    typedef struct {
        logic [1:0] op;
        logic [3:0] mask;
        logic [3:0] data;
        int         fault;
        logic [3:0] exp_j;
        logic [3:0] exp_k;
        logic       exp_err;
        logic [3:0] exp_bits;
        int         exp_lat;
        int         exp_strobes;
        logic [3:0] exp_q;
    } vec_t;

    typedef struct {
        logic       err;
        logic [3:0] bits;
        int         lat;
        int         strobes;
        logic [3:0] q;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        exp_t e;
        int   lat;
        int   strobes;
        int   bad;
        int   t;
        bit   got;
        fault_mode = v.fault;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = v.op;
        in_mask  = v.mask;
        in_data  = v.data;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("v%0d_accept", idx), {31'b0, in_ready}, 32'd1);
        sb.push_back('{v.exp_err, v.exp_bits, v.exp_lat, v.exp_strobes, v.exp_q});
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d_drive_j", idx), {28'b0, j}, {28'b0, v.exp_j});
        chk($sformatf("v%0d_drive_k", idx), {28'b0, k}, {28'b0, v.exp_k});
        lat = 1;
        strobes = 0;
        bad = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            if ((j | k) != 4'b0000) begin
                strobes++;
                if (j !== v.exp_j || k !== v.exp_k) bad++;
            end
            if (done || err) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk($sformatf("v%0d_completed", idx), {31'b0, got}, 32'd1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d_done_err_excl", idx), {31'b0, done & err}, 32'd0);
            chk($sformatf("v%0d_err", idx), {31'b0, err}, {31'b0, e.err});
            chk($sformatf("v%0d_done", idx), {31'b0, done}, {31'b0, ~e.err});
            chk($sformatf("v%0d_err_bits", idx), {28'b0, err_bits}, {28'b0, e.bits});
            chk($sformatf("v%0d_latency", idx), lat, e.lat);
            chk($sformatf("v%0d_strobes", idx), strobes, e.strobes);
            chk($sformatf("v%0d_strobe_pattern", idx), bad, 0);
            chk($sformatf("v%0d_bank_q", idx), {28'b0, q_fb}, {28'b0, e.q});
        end
    endtask

    initial begin
        int t;
        int n;
        int d1;
        int d2;
        int evts;
        logic rdy_at_d1;

        //            op     mask     data     flt j        k        err   bits     lat str q
        vecs[0] = '{2'b00, 4'b1111, 4'b1010, 0, 4'b1010, 4'b0000, 1'b0, 4'b0000, 5,  1, 4'b1010};
        vecs[1] = '{2'b11, 4'b0110, 4'b0000, 0, 4'b0100, 4'b0010, 1'b0, 4'b0000, 5,  1, 4'b1100};
        vecs[2] = '{2'b01, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 1'b1, 4'b0001, 13, 3, 4'b1100};
        vecs[3] = '{2'b00, 4'b1111, 4'b0100, 0, 4'b0000, 4'b1000, 1'b0, 4'b0000, 5,  1, 4'b0100};
        vecs[4] = '{2'b10, 4'b0100, 4'b0000, 2, 4'b0000, 4'b0100, 1'b0, 4'b0000, 9,  2, 4'b0000};
        vecs[5] = '{2'b00, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 5,  0, 4'b0000};
        vecs[6] = '{2'b01, 4'b1001, 4'b0000, 0, 4'b1001, 4'b0000, 1'b0, 4'b0000, 5,  1, 4'b1001};
        vecs[7] = '{2'b10, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 5,  1, 4'b1000};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_mask  = 4'b0000;
        in_data  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_j", {28'b0, j}, 32'd0);
        chk("rst_k", {28'b0, k}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_err_bits", {28'b0, err_bits}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_cmd(vecs[i], i);

        // Reset while a LOAD is in WAIT: abandoned command must not report
        fault_mode = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_mask  = 4'b1111;
        in_data  = 4'b1111;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_j", {28'b0, j}, 32'd0);
        chk("midrst_k", {28'b0, k}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        evts = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || err) evts++;
            @(negedge clk);
        end
        chk("midrst_no_report", evts, 0);
        run_cmd('{2'b00, 4'b1111, 4'b0011, 0, 4'b0000, 4'b1100, 1'b0, 4'b0000, 5, 1, 4'b0011}, 8);

        // Back-to-back with in_valid held high across two commands
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_mask  = 4'b1111;
        in_data  = 4'b1111;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        d1 = -1;
        d2 = -1;
        rdy_at_d1 = 1'b0;
        while (n < 20 && d2 < 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_op   = 2'b10;
                in_data = 4'b0000;
            end
            if (n == 6) in_valid = 1'b0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    rdy_at_d1 = in_ready & in_valid;
                end else begin
                    d2 = n;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_first_done", d1, 5);
        chk("b2b_accept_in_done_cycle", {31'b0, rdy_at_d1}, 32'd1);
        chk("b2b_second_done", d2, 10);
        chk("b2b_bank_q", {28'b0, q_fb}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Drive-side controller for a bank of JK master-slave flip-flops. It accepts high-level commands (load value, set, clear, toggle) over a valid/ready handshake. It converts each command into single-cycle J/K strobes using the JK excitation table. It then waits a settle interval, reads the bank's Q back, retries on mismatch and reports done or error.

## Interface
Parameters:
- WIDTH, 4, number of JK flops in the driven bank
- SETTLE, 2, idle cycles between a J/K strobe and the Q check (≥1)
- MAX_RETRY, 2, re-drive attempts after a failed check (≥0)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  controller can accept a command
- in_op  in  2  00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE
- in_mask  in  WIDTH  bits affected by the command; unmasked bits are held
- in_data  in  WIDTH  target value for LOAD; ignored otherwise
- q_fb  in  WIDTH  Q outputs of the driven flop bank
- j  out  WIDTH  J inputs to the bank
- k  out  WIDTH  K inputs to the bank
- done  out  1  one-cycle pulse: masked bits match target
- err  out  1  one-cycle pulse: retries exhausted with mismatch
- err_bits  out  WIDTH  masked mismatch bits, valid with err, held until next accept

## Operation
- FSM states: IDLE, DRIVE, WAIT, CHECK.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch the mask M and the snapshot S=q_fb;
  - compute target T per bit i: LOAD T=in_data, SET T=1, CLEAR T=0, TOGGLE T=~S;
  - for unmasked bits, T=S;
  - clear the retry count; go to DRIVE.
- DRIVE (exactly 1 cycle): j = M & ~S & T; k = M & S & ~T. Don't-cares resolve to 0, so no bit ever sees J=K=1. TOGGLE is therefore issued as targeted set/clear. Go to WAIT.
- WAIT: j=k=0 for SETTLE cycles, then CHECK.
- CHECK (1 cycle, j=k=0): compute D = (q_fb ^ T) & M.
  - D=0: go to IDLE and pulse done.
  - D≠0 and retry<MAX_RETRY: retry++, S=q_fb, go to DRIVE. Re-drive uses the excitation table from the current Q, never a second toggle.
  - D≠0 and retries exhausted: go to IDLE, pulse err, err_bits=D.
- in_mask=0: the command is accepted and the DRIVE strobes are all 0. The check passes and done pulses at normal latency.
- j and k are 0 in every state except DRIVE.
- Commands presented while in_ready=0 are not accepted. in_valid may stay high; the next command is taken in the first IDLE cycle.

## Timing
- Reset (rst high at an edge) leaves:
  - state=IDLE, j=0, k=0, done=0, err=0, err_bits=0, retry=0;
  - in_ready=1 from the following cycle.
- Reset mid-operation: any state returns to IDLE at that edge. j/k go to 0 immediately, and done/err are not pulsed for the abandoned command.
- Accept at edge N:
  - DRIVE occupies cycle N+1;
  - WAIT occupies N+2 … N+1+SETTLE;
  - CHECK occupies N+2+SETTLE;
  - done/err are registered high in cycle N+3+SETTLE, the cycle in which in_ready is high again.
- Back-to-back: a new command can be accepted in the same cycle that done/err is high. The throughput is one command per SETTLE+3 cycles.
- Each retry adds SETTLE+2 cycles, so the worst case is (MAX_RETRY+1)(SETTLE+2)+1 cycles from accept to err.
- q_fb is sampled only at the accept edge and in CHECK. It is treated as synchronous to clk.
- done and err are never high in the same cycle.

## Test plan
All scenarios use WIDTH=4, SETTLE=2, MAX_RETRY=2, with a behavioural JK master-slave bank wired to j/k/q_fb.

- Reset, then bank Q=0000; LOAD data=1010, mask=1111 → DRIVE cycle j=1010, k=0000. done pulses 5 cycles after accept with Q=1010 and err=0.
- From Q=1010, TOGGLE mask=0110 → j=0100, k=0010 in the single DRIVE cycle. Q=1100 and done pulses; j=k=0 outside DRIVE.
- Fault injection: stick bit 0 of the bank at 0; SET mask=0001 → three DRIVE strobes with j=0001, then err=1 and err_bits=0001. err pulses 13 cycles after accept, and done stays 0.
- Transient fault: bit 2 ignores only the first strobe; CLEAR mask=0100 from Q=0100 → one retry with k=0100 again. done pulses at 9 cycles after accept.
- rst asserted during WAIT of a LOAD → next cycle j=k=0 and in_ready=1. No done/err appears, and a new LOAD 0011 completes normally.
- in_valid held high with two queued commands (LOAD 1111, then CLEAR 1111) → the second is accepted in the done cycle of the first. Q ends at 0000 with two done pulses 5 cycles apart.
